// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: instruction sequencer driving reg_bank reads/writes and ALUX start/done handshake.
module alu_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             instr_ld,
  input  logic [3:0]       instr_opr,
  input  logic [3:0]       instr_rd,
  input  logic [3:0]       instr_ra,
  input  logic [3:0]       instr_rb,
  input  logic             instr_cnstA,
  input  logic             instr_cnstB,
  input  logic [1:0]       instr_wmode,
  input  logic             err_clr,
  output logic             regwen,
  output logic [3:0]       selwreg,
  output logic [1:0]       endwreg,
  output logic [3:0]       seloutA,
  output logic [3:0]       seloutB,
  output logic             cnstA,
  output logic             cnstB,
  output logic             enrregA,
  output logic             enrregB,
  output logic             wdata_sel,
  output logic [3:0]       alu_opr,
  output logic             alu_start,
  input  logic             alu_done,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_WAIT, S_WB, S_ERR} state_t;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t r_state, w_next;
  logic [TW-1:0] r_wcnt;
  logic [CNT_W-1:0] r_cnt;
  logic r_ld, r_ca, r_cb, r_err;
  logic [3:0] r_opr, r_rd, r_ra, r_rb;
  logic [1:0] r_wm;
  logic w_acc, w_tmo, w_wb;
  assign w_acc = instr_valid & instr_ready;
  // r_wcnt holds the number of WAIT cycles already completed
  assign w_tmo = (r_wcnt == TW'(TIMEOUT_CYCLES - 1));
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_acc ? (instr_ld ? S_WB : S_READ) : S_IDLE;
      S_READ:  w_next = S_EXEC;
      S_EXEC:  w_next = S_WAIT;
      S_WAIT:  w_next = alu_done ? S_WB : (w_tmo ? S_ERR : S_WAIT);
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_ld    <= 1'b0;
      r_ca    <= 1'b0;
      r_cb    <= 1'b0;
      r_opr   <= '0;
      r_rd    <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_wm    <= '0;
    end else begin
      r_state <= w_next;
      r_wcnt  <= (r_state == S_WAIT) ? r_wcnt + TW'(1) : '0;
      r_err   <= (r_state == S_ERR) | (r_err & ~err_clr);
      if (r_state == S_WB) r_cnt <= r_cnt + CNT_W'(1);
      if (w_acc) begin
        r_ld  <= instr_ld;
        r_ca  <= instr_cnstA;
        r_cb  <= instr_cnstB;
        r_opr <= instr_opr;
        r_rd  <= instr_rd;
        r_ra  <= instr_ra;
        r_rb  <= instr_rb;
        r_wm  <= instr_wmode;
      end
    end
  end
  assign instr_ready = (r_state == S_IDLE);
  assign busy        = ~instr_ready;
  assign w_wb        = (r_state == S_WB);
  assign regwen      = w_wb;
  assign selwreg     = w_wb ? r_rd : '0;
  assign endwreg     = w_wb ? r_wm : '0;
  assign wdata_sel   = w_wb & r_ld;
  assign seloutA     = busy ? r_ra : '0;
  assign seloutB     = busy ? r_rb : '0;
  assign cnstA       = busy & r_ca;
  assign cnstB       = busy & r_cb;
  assign enrregA     = (r_state == S_READ);
  assign enrregB     = (r_state == S_READ);
  assign alu_opr     = busy ? r_opr : '0;
  assign alu_start   = (r_state == S_EXEC);
  assign err         = r_err;
  assign instr_count = r_cnt;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed checks of load, ALU op, timeout, error clear, reset abort and back-to-back loads.
module tb_alu_seq_ctrl;
  logic clock = 0, reset = 1;
  logic instr_valid = 0, instr_ld = 0, instr_cnstA = 0, instr_cnstB = 0, err_clr = 0, alu_done = 0;
  logic [3:0] instr_opr = 0, instr_rd = 0, instr_ra = 0, instr_rb = 0;
  logic [1:0] instr_wmode = 0;
  logic instr_ready, regwen, cnstA, cnstB, enrregA, enrregB, wdata_sel, alu_start, busy, err;
  logic [3:0] selwreg, seloutA, seloutB, alu_opr;
  logic [1:0] endwreg;
  logic [15:0] instr_count;
  int checks = 0, errors = 0, nwr;
  alu_seq_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_ld(instr_ld), .instr_opr(instr_opr), .instr_rd(instr_rd), .instr_ra(instr_ra),
    .instr_rb(instr_rb), .instr_cnstA(instr_cnstA), .instr_cnstB(instr_cnstB),
    .instr_wmode(instr_wmode), .err_clr(err_clr), .regwen(regwen), .selwreg(selwreg),
    .endwreg(endwreg), .seloutA(seloutA), .seloutB(seloutB), .cnstA(cnstA), .cnstB(cnstB),
    .enrregA(enrregA), .enrregB(enrregB), .wdata_sel(wdata_sel), .alu_opr(alu_opr),
    .alu_start(alu_start), .alu_done(alu_done), .busy(busy), .err(err), .instr_count(instr_count)
  );
  always #5 clock = ~clock;
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic alu_instr(input logic [3:0] opr, ra, rb, rd, input logic ca, cb, input logic [1:0] wm);
    instr_ld = 0; instr_opr = opr; instr_ra = ra; instr_rb = rb; instr_rd = rd;
    instr_cnstA = ca; instr_cnstB = cb; instr_wmode = wm; instr_valid = 1;
  endtask
  initial begin
    tick; tick;
    reset = 0;
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_regwen", regwen, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_err", err, 0);
    chk("rst_start", alu_start, 0);
    // 1: load rd=3
    instr_ld = 1; instr_rd = 3; instr_wmode = 0; instr_valid = 1;
    tick; instr_valid = 0;
    chk("ld_regwen", regwen, 1);
    chk("ld_selwreg", selwreg, 3);
    chk("ld_wdata_sel", wdata_sel, 1);
    chk("ld_ready", instr_ready, 0);
    tick;
    chk("ld_regwen_off", regwen, 0);
    chk("ld_count", instr_count, 1);
    chk("ld_ready_back", instr_ready, 1);
    // 2: ALU op, done in first WAIT cycle
    alu_instr(2, 1, 2, 5, 1, 0, 2);
    tick; instr_valid = 0; instr_rd = 0;
    chk("op_enrregA", enrregA, 1);
    chk("op_enrregB", enrregB, 1);
    chk("op_seloutA", seloutA, 1);
    chk("op_seloutB", seloutB, 2);
    chk("op_cnstA", cnstA, 1);
    chk("op_opr_read", alu_opr, 2);
    chk("op_start_read", alu_start, 0);
    tick;
    chk("op_start", alu_start, 1);
    chk("op_enr_exec", enrregA, 0);
    chk("op_regwen_exec", regwen, 0);
    alu_done = 1;
    tick;
    chk("op_start_wait", alu_start, 0);
    chk("op_regwen_wait", regwen, 0);
    chk("op_opr_wait", alu_opr, 2);
    tick; alu_done = 0;
    chk("op_regwen", regwen, 1);
    chk("op_selwreg", selwreg, 5);
    chk("op_endwreg", endwreg, 2);
    chk("op_wdata_sel", wdata_sel, 0);
    tick;
    chk("op_count", instr_count, 2);
    chk("op_idle", instr_ready, 1);
    // 3: timeout after 4 WAIT cycles, set wins over simultaneous clear
    alu_instr(4, 6, 7, 7, 0, 1, 1);
    tick; instr_valid = 0;
    nwr = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      nwr += int'(regwen);
    end
    chk("to_busy_wait4", busy, 1);
    chk("to_err_pre", err, 0);
    tick;
    nwr += int'(regwen);
    chk("to_err_state_busy", busy, 1);
    err_clr = 1;
    tick; err_clr = 0;
    chk("to_no_write", nwr, 0);
    chk("to_err", err, 1);
    chk("to_count", instr_count, 2);
    chk("to_ready", instr_ready, 1);
    // 4: clear error, next instruction completes
    err_clr = 1;
    tick; err_clr = 0;
    chk("clr_err", err, 0);
    instr_ld = 1; instr_rd = 9; instr_valid = 1;
    tick; instr_valid = 0;
    chk("clr_regwen", regwen, 1);
    chk("clr_selwreg", selwreg, 9);
    tick;
    chk("clr_count", instr_count, 3);
    // 5: reset during WAIT
    alu_instr(1, 3, 4, 8, 1, 1, 3);
    tick; instr_valid = 0;
    tick; tick;
    chk("rw_in_wait", busy, 1);
    reset = 1;
    tick; reset = 0;
    chk("rw_ready", instr_ready, 1);
    chk("rw_busy", busy, 0);
    chk("rw_regwen", regwen, 0);
    chk("rw_seloutA", seloutA, 0);
    chk("rw_cnstB", cnstB, 0);
    chk("rw_opr", alu_opr, 0);
    chk("rw_count", instr_count, 0);
    // 6: 16 back-to-back loads
    instr_ld = 1; instr_wmode = 0; instr_valid = 1;
    nwr = 0;
    for (int i = 0; i < 16; i++) begin
      instr_rd = 4'(i);
      tick;
      nwr += int'(regwen);
      chk("b2b_selwreg", selwreg, i);
      tick;
      nwr += int'(regwen);
    end
    instr_valid = 0;
    chk("b2b_writes", nwr, 16);
    chk("b2b_count", instr_count, 16);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
